// File: rtl/hs_pkg.sv
// hs_pkg: shared event codes, expected-actuator decode and default scan length
package hs_pkg;
  localparam logic [2:0] CODE_IDLE   = 3'd0;
  localparam logic [2:0] CODE_FDOOR  = 3'd1;
  localparam logic [2:0] CODE_RDOOR  = 3'd2;
  localparam logic [2:0] CODE_FIRE   = 3'd3;
  localparam logic [2:0] CODE_WINDOW = 3'd4;
  localparam logic [2:0] CODE_HEAT   = 3'd5;
  localparam logic [2:0] CODE_COOL   = 3'd6;
  localparam logic [2:0] CODE_ILL    = 3'd7;
  localparam int SCAN_LEN_DEF = 13;
  function automatic logic [5:0] exp_act(input logic [2:0] code);
    return (code == CODE_IDLE || code == CODE_ILL) ? 6'b000000 : 6'b100000 >> (code - 3'd1);
  endfunction
endpackage

// File: rtl/hs_event_fifo.sv
// hs_event_fifo: synchronous FIFO, push ignored when full unless popping in the same cycle
//   Clk, Rst_n (async active-low) | push/din write side | pop/dout read side (dout=0 when empty)
//   full, empty status
module hs_event_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign dout    = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge Clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/hs_event_logger.sv
// hs_event_logger: checks controller {act,display} stream, keeps saturating counters, queues code-change events
//   Clk, Rst_n (async active-low) | display/act sampled each posedge | clr sync clear
//   sel -> cnt_out (registered counter readback) | ev_valid/ev_ready/ev_code/ev_slot event stream
//   proto_err, overflow sticky flags
module hs_event_logger
  import hs_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int SCAN_LEN   = SCAN_LEN_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [2:0]       display,
  input  logic [5:0]       act,
  input  logic             clr,
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] cnt_out,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [2:0]       ev_code,
  output logic [3:0]       ev_slot,
  output logic             proto_err,
  output logic             overflow
);
  logic [CNT_W-1:0] cnt [8];
  logic [2:0] prev_code, idx;
  logic [3:0] slot;
  logic [6:0] head;
  logic match, push, pop, inc, full, empty;
  // entry 0 is the error count; entry 7 is never incremented so sel=7 reads 0
  always_comb begin
    match = display != CODE_ILL && act == exp_act(display);
    push  = match && display != CODE_IDLE && display != prev_code;
    pop   = ev_valid && ev_ready;
    idx   = match ? display : CODE_IDLE;
    inc   = !match || display != CODE_IDLE;
  end
  hs_event_fifo #(.WIDTH(7), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .push  (push),
    .din   ({slot, display}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  assign ev_valid = !empty;
  assign ev_code  = head[2:0];
  assign ev_slot  = head[6:3];
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
      prev_code <= '0;
      slot      <= '0;
      cnt_out   <= '0;
      proto_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      slot    <= slot == 4'(SCAN_LEN - 1) ? '0 : slot + 4'd1;
      cnt_out <= cnt[sel];
      if (clr) begin
        for (int i = 0; i < 8; i++) cnt[i] <= '0;
        prev_code <= '0;
        proto_err <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        prev_code <= display;
        if (inc && cnt[idx] != '1) cnt[idx] <= cnt[idx] + CNT_W'(1);
        if (!match) proto_err <= 1'b1;
        if (push && full && !pop) overflow <= 1'b1;
      end
    end
endmodule
